// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the RV32I-subset datapath.
// Latches the fetched instruction, decodes it, then steps EXEC/MEM/WBK while
// driving the datapath controls. Memory accesses wait on mem_ready with a
// bounded timeout. Illegal instructions and memory timeouts park in a sticky
// TRAP state that only rst clears.
//
// Optional build macro: CTRL_PERF_CNT_EN adds the cyc_cnt_o / ret_cnt_o
// performance counters and the CNT_W parameter.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | wait for run_i, latch inst_i into ir
// DECODE | classify ir; illegal encodings go to TRAP
// EXEC   | ALU step; branches resolve and retire here
// MEM    | RAM request held until mem_ready_i or timeout
// WBK    | register-file write and retire
// TRAP   | sticky fault, all strobes low, exit via rst only
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
`ifdef CTRL_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [31:0]      inst_i,
  input  logic [3:0]       status_i,
  input  logic             mem_ready_i,
  output logic             PCsrc_o,
  output logic             pc_en_o,
  output logic             ALUsrc_o,
  output logic             MemRW_o,
  output logic             mem_req_o,
  output logic             WB_o,
  output logic             RegRW_o,
  output logic [1:0]       immSel_o,
  output logic [2:0]       ALUop_o,
  output logic [2:0]       state_o,
  output logic             retire_o,
  output logic             trap_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] ret_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WBK    = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ILL,
    C_R,
    C_I,
    C_LW,
    C_SW,
    C_BR
  } cls_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  // Timeout down-counter: loaded with MEM_TIMEOUT on MEM entry, terminal
  // count at zero. A zero MEM_TIMEOUT disables the timeout entirely.
  localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TIMEOUT);
  localparam bit TMO_ON = (MEM_TIMEOUT != 0);

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  cls_t       cls;
  logic [2:0] alu_op;
  logic       alu_src;
  logic [1:0] imm_sel;
  logic       wb_sel;
  logic       br_taken;
  logic       dp_active;
  logic       unused_bits;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // Register indices and immediates belong to the datapath; carry flag unused.
  assign unused_bits = ^{ir_q[24:15], ir_q[11:7], status_i[2]};

  // Instruction classification, including funct3/funct7 legality.
  always_comb begin
    cls = C_ILL;
    case (opcode)
      OPC_R: begin
        if ((funct7 == 7'b0000000 && funct3 != 3'b011) ||
            (funct7 == 7'b0100000 && funct3 == 3'b000))
          cls = C_R;
      end
      OPC_I: begin
        if (funct3 != 3'b011 &&
            !((funct3 == 3'b001 || funct3 == 3'b101) && funct7 != 7'b0000000))
          cls = C_I;
      end
      OPC_LW: begin
        if (funct3 == 3'b010)
          cls = C_LW;
      end
      OPC_SW: begin
        if (funct3 == 3'b010)
          cls = C_SW;
      end
      OPC_BR: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 ||
            funct3 == 3'b100 || funct3 == 3'b101)
          cls = C_BR;
      end
      default: cls = C_ILL;
    endcase
  end

  // Datapath control values; constant for the whole EXEC..WBK window.
  always_comb begin
    alu_op  = OP_ADD;
    alu_src = 1'b0;
    imm_sel = 2'b00;
    wb_sel  = 1'b0;
    case (cls)
      C_R, C_I: begin
        alu_src = (cls == C_I);
        wb_sel  = 1'b1;
        case (funct3)
          3'b000:  alu_op = (cls == C_R && funct7[5]) ? OP_SUB : OP_ADD;
          3'b111:  alu_op = OP_AND;
          3'b110:  alu_op = OP_OR;
          3'b100:  alu_op = OP_XOR;
          3'b001:  alu_op = OP_SLL;
          3'b101:  alu_op = OP_SRL;
          3'b010:  alu_op = OP_SLT;
          default: alu_op = OP_ADD;
        endcase
      end
      C_LW: begin
        alu_src = 1'b1;
        imm_sel = 2'b00;
      end
      C_SW: begin
        alu_src = 1'b1;
        imm_sel = 2'b01;
      end
      C_BR: begin
        alu_op  = OP_SUB;
        imm_sel = 2'b10;
      end
      default: ;
    endcase
  end

  // Branch condition from the ALU flags of the compare.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = status_i[0];
      3'b001:  br_taken = ~status_i[0];
      3'b100:  br_taken = status_i[1] ^ status_i[3];
      3'b101:  br_taken = ~(status_i[1] ^ status_i[3]);
      default: br_taken = 1'b0;
    endcase
  end

  assign dp_active = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WBK);

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    tmo_d     = tmo_q;
    PCsrc_o   = 1'b0;
    pc_en_o   = 1'b0;
    MemRW_o   = 1'b0;
    mem_req_o = 1'b0;
    RegRW_o   = 1'b0;
    retire_o  = 1'b0;
    trap_o    = 1'b0;
    ALUsrc_o  = dp_active ? alu_src : 1'b0;
    ALUop_o   = dp_active ? alu_op  : 3'b000;
    immSel_o  = dp_active ? imm_sel : 2'b00;
    WB_o      = dp_active ? wb_sel  : 1'b0;

    case (state_q)
      S_FETCH: begin
        if (run_i) begin
          ir_d    = inst_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (cls == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          C_R, C_I: state_d = S_WBK;
          C_LW, C_SW: begin
            tmo_d   = TMO_LOAD;
            state_d = S_MEM;
          end
          C_BR: begin
            pc_en_o  = 1'b1;
            retire_o = 1'b1;
            PCsrc_o  = br_taken;
            state_d  = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        MemRW_o   = (cls == C_SW);
        if (mem_ready_i) begin
          if (cls == C_LW) begin
            state_d = S_WBK;
          end else begin
            pc_en_o  = 1'b1;
            retire_o = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (TMO_ON && tmo_q == '0) begin
          state_d = S_TRAP;
        end else if (tmo_q != '0) begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_WBK: begin
        RegRW_o  = 1'b1;
        pc_en_o  = 1'b1;
        retire_o = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        trap_o = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // State, instruction and timeout registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      tmo_q   <= tmo_d;
    end
  end

  assign state_o = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  // Counter increments; both wrap naturally.
  always_comb begin
    cyc_d = (state_q != S_TRAP) ? cyc_q + CNT_W'(1) : cyc_q;
    ret_d = retire_o ? ret_q + CNT_W'(1) : ret_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cyc_cnt_o = cyc_q;
  assign ret_cnt_o = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instructions, per-cycle comparison
// against an instruction-level trace model built from the ISA rules.
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 15;
  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BR = 5;
  // ALUop by funct3 for R/I: ADD SLL SLT - XOR SRL OR AND
  localparam int F3_ALU [8] = '{0, 5, 7, 0, 4, 6, 3, 2};

  logic        clk, rst, run, mem_ready;
  logic [31:0] inst;
  logic [3:0]  status;
  logic        PCsrc_o, pc_en_o, ALUsrc_o, MemRW_o, mem_req_o, WB_o, RegRW_o;
  logic [1:0]  immSel_o;
  logic [2:0]  ALUop_o, state_o;
  logic        retire_o, trap_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt_o, ret_cnt_o;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       pcsrc, pc_en, alusrc, memrw, mem_req, wb, regrw;
    logic [1:0] imm;
    logic [2:0] aluop;
    logic       retire, trap;
  } out_t;

  out_t act;
  assign act = {state_o, PCsrc_o, pc_en_o, ALUsrc_o, MemRW_o, mem_req_o, WB_o,
                RegRW_o, immSel_o, ALUop_o, retire_o, trap_o};

  out_t        tr_exp [$];
  logic        tr_run [$];
  logic        tr_rdy [$];
  logic [31:0] tr_inst[$];

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
`ifdef CTRL_PERF_CNT_EN
    , .CNT_W(32)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .inst_i(inst), .status_i(status),
    .mem_ready_i(mem_ready), .PCsrc_o(PCsrc_o), .pc_en_o(pc_en_o),
    .ALUsrc_o(ALUsrc_o), .MemRW_o(MemRW_o), .mem_req_o(mem_req_o), .WB_o(WB_o),
    .RegRW_o(RegRW_o), .immSel_o(immSel_o), .ALUop_o(ALUop_o), .state_o(state_o),
    .retire_o(retire_o), .trap_o(trap_o)
`ifdef CTRL_PERF_CNT_EN
    , .cyc_cnt_o(cyc_cnt_o), .ret_cnt_o(ret_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int classify(input logic [31:0] i);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    if (op == 7'h33)
      return ((f7 == 7'h00 && f3 != 3'd3) || (f7 == 7'h20 && f3 == 3'd0)) ? K_R : K_ILL;
    if (op == 7'h13) begin
      if (f3 == 3'd3) return K_ILL;
      if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) return K_ILL;
      return K_I;
    end
    if (op == 7'h03) return (f3 == 3'd2) ? K_LW : K_ILL;
    if (op == 7'h23) return (f3 == 3'd2) ? K_SW : K_ILL;
    if (op == 7'h63) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) ? K_BR : K_ILL;
    return K_ILL;
  endfunction

  function automatic logic [2:0] model_aluop(input int k, input logic [31:0] i);
    int v;
    v = 0;
    if (k == K_R || k == K_I) begin
      v = F3_ALU[i[14:12]];
      if (k == K_R && i[14:12] == 3'd0 && i[30]) v = 1;
    end else if (k == K_BR) begin
      v = 1;
    end
    return 3'(v);
  endfunction

  function automatic logic model_taken(input logic [2:0] f3, input logic [3:0] s);
    logic z, n, v;
    z = s[0]; n = s[1]; v = s[3];
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n != v;
      3'd5: return n == v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input out_t o, input logic r, input logic rd, input logic [31:0] iv);
    tr_exp.push_back(o); tr_run.push_back(r); tr_rdy.push_back(rd); tr_inst.push_back(iv);
  endtask

  // Expected per-cycle outputs for one instruction, starting in FETCH.
  // waits: mem_ready-low cycles in MEM; stall: FETCH cycles with run=0;
  // hold: TRAP cycles to observe if the instruction faults.
  task automatic build(input logic [31:0] i, input logic [3:0] s, input int waits,
                       input int stall, input int hold);
    int   k;
    out_t o, base;
    logic rdy;
    k = classify(i);
    tr_exp.delete(); tr_run.delete(); tr_rdy.delete(); tr_inst.delete();
    o = '0;
    for (int n = 0; n < stall; n++) push(o, 1'b0, 1'b1, i);
    push(o, 1'b1, 1'b1, i);
    o.st = 3'd1;
    push(o, 1'b1, 1'b1, 32'hFFFF_FFFF);
    if (k == K_ILL) begin
      o = '0; o.st = 3'd5; o.trap = 1'b1;
      for (int n = 0; n < hold; n++) push(o, 1'b1, 1'b1, 32'hFFFF_FFFF);
      return;
    end
    base        = '0;
    base.alusrc = (k == K_I || k == K_LW || k == K_SW);
    base.imm    = (k == K_SW) ? 2'd1 : (k == K_BR) ? 2'd2 : 2'd0;
    base.aluop  = model_aluop(k, i);
    base.wb     = (k == K_R || k == K_I);
    o = base; o.st = 3'd2;
    if (k == K_BR) begin
      o.pc_en = 1'b1; o.retire = 1'b1; o.pcsrc = model_taken(i[14:12], s);
    end
    push(o, 1'b1, 1'b1, 32'hFFFF_FFFF);
    if (k == K_BR) return;
    if (k == K_LW || k == K_SW) begin
      for (int j = 0; j < 1000; j++) begin
        rdy = (j >= waits);
        o = base; o.st = 3'd3; o.mem_req = 1'b1; o.memrw = (k == K_SW);
        if (rdy && k == K_SW) begin o.pc_en = 1'b1; o.retire = 1'b1; end
        push(o, 1'b1, rdy, 32'hFFFF_FFFF);
        if (rdy) break;
        if (MEM_TIMEOUT != 0 && j == MEM_TIMEOUT) begin
          o = '0; o.st = 3'd5; o.trap = 1'b1;
          for (int n = 0; n < hold; n++) push(o, 1'b1, 1'b1, 32'hFFFF_FFFF);
          return;
        end
      end
      if (k == K_SW) return;
    end
    o = base; o.st = 3'd4; o.regrw = 1'b1; o.pc_en = 1'b1; o.retire = 1'b1;
    push(o, 1'b1, 1'b1, 32'hFFFF_FFFF);
  endtask

  // Drive the trace cycle by cycle and compare outputs mid-cycle.
  task automatic execute(input string tag, input logic [3:0] s, input int limit);
    int n;
    n = (limit > 0 && limit < tr_exp.size()) ? limit : tr_exp.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      run = tr_run[k]; mem_ready = tr_rdy[k]; inst = tr_inst[k]; status = s;
      @(negedge clk);
      checks++;
      if (act !== tr_exp[k]) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs actual=%b required=%b (st,pcsrc,pc_en,alusrc,memrw,mem_req,wb,regrw,imm,aluop,retire,trap)",
                 tag, k, act, tr_exp[k]);
      end
    end
  endtask

  task automatic do_instr(input string tag, input logic [31:0] i, input logic [3:0] s,
                          input int waits, input int stall, input int hold);
    build(i, s, waits, stall, hold);
    execute(tag, s, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, a, e);
    end
  endtask

  task automatic do_reset(input string tag);
    run = 1'b0; rst = 1'b1; #1;
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_trap"}, 32'(trap_o), 32'd0);
    chk({tag, "_outs"}, 32'(act), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] ill [7];
    ill = '{32'h0000_0000, 32'h4020_91B3, 32'h4050_D093, 32'h0000_8283,
            32'h0020_E463, 32'h0020_B1B3, 32'h0000_006F};
    rst = 1'b0; run = 1'b0; inst = '0; status = '0; mem_ready = 1'b0;
    #1 rst = 1'b1;
    #10;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_outs", 32'(act), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Model pins from hand-computed latencies and fields.
    build(32'h0020_81B3, 4'd0, 0, 0, 0);
    chk("model_add_len", 32'(tr_exp.size()), 32'd4);
    chk("model_add_wbk", 32'({tr_exp[3].st, tr_exp[3].regrw, tr_exp[3].wb}), 32'b100_1_1);
    build(32'h0040_A283, 4'd0, 2, 0, 0);
    chk("model_lw_len", 32'(tr_exp.size()), 32'd7);
    chk("model_lw_wb", 32'(tr_exp[6].wb), 32'd0);
    build(32'h0020_8463, 4'b0001, 0, 0, 0);
    chk("model_beq_len", 32'(tr_exp.size()), 32'd3);
    chk("model_beq_pcsrc", 32'(tr_exp[2].pcsrc), 32'd1);
    build(32'h4020_81B3, 4'd0, 0, 0, 0);
    chk("model_sub_aluop", 32'(tr_exp[2].aluop), 32'd1);
    build(32'h0020_A223, 4'd0, 1000, 0, 4);
    chk("model_sw_tmo_len", 32'(tr_exp.size()), 32'd23);
    chk("model_sw_tmo_edge", 32'({tr_exp[18].st, tr_exp[19].st}), 32'b011_101);

    do_instr("add", 32'h0020_81B3, 4'd0, 0, 0, 0);
    do_instr("add_stall", 32'h0020_81B3, 4'd0, 0, 3, 0);
    do_instr("sub", 32'h4020_81B3, 4'd0, 0, 0, 0);
    for (int f = 0; f < 8; f++) begin
      if (f == 3) continue;
      do_instr("r_op", {7'd0, 5'd2, 5'd1, 3'(f), 5'd3, 7'b0110011}, 4'd0, 0, 0, 0);
      do_instr("i_op", {12'd5, 5'd1, 3'(f), 5'd1, 7'b0010011}, 4'd0, 0, 0, 0);
    end
    do_instr("lw_w2", 32'h0040_A283, 4'd0, 2, 0, 0);
    do_instr("lw_w0", 32'h0040_A283, 4'd0, 0, 0, 0);
    do_instr("sw_w0", 32'h0020_A223, 4'd0, 0, 0, 0);
    do_instr("sw_w3", 32'h0020_A223, 4'd0, 3, 0, 0);
    do_instr("beq_t", 32'h0020_8463, 4'b0001, 0, 0, 0);
    do_instr("beq_nt", 32'h0020_8463, 4'b0000, 0, 0, 0);
    do_instr("bne_t", 32'h0020_9463, 4'b0000, 0, 0, 0);
    do_instr("blt_t", 32'h0020_C463, 4'b0010, 0, 0, 0);
    do_instr("bge_nt", 32'h0020_D463, 4'b0010, 0, 0, 0);
    do_instr("bge_t", 32'h0020_D463, 4'b1010, 0, 0, 0);

    do_instr("ill_zero", 32'h0000_0000, 4'd0, 0, 0, 20);
    do_reset("ill_zero_rst");
    for (int n = 1; n < 7; n++) begin
      do_instr("ill", ill[n], 4'd0, 0, 0, 3);
      do_reset("ill_rst");
    end

    do_instr("sw_timeout", 32'h0020_A223, 4'd0, 1000, 0, 4);
    do_reset("sw_timeout_rst");

    build(32'h0020_81B3, 4'd0, 0, 0, 0);
    execute("rst_wbk", 4'd0, 4);
    run = 1'b0; rst = 1'b1; #1;
    chk("rst_wbk_regrw", 32'(RegRW_o), 32'd0);
    chk("rst_wbk_pc_en", 32'(pc_en_o), 32'd0);
    chk("rst_wbk_retire", 32'(retire_o), 32'd0);
    chk("rst_wbk_state", 32'(state_o), 32'd0);
    #2 rst = 1'b0;
    do_instr("post_rst_add", 32'h0020_81B3, 4'd0, 0, 3, 0);

`ifdef CTRL_PERF_CNT_EN
    do_reset("perf_rst");
    for (int n = 0; n < 10; n++) do_instr("perf_add", 32'h0020_81B3, 4'd0, 0, 0, 0);
    @(posedge clk); #1;
    chk("perf_ret_cnt", ret_cnt_o, 32'd10);
    chk("perf_cyc_cnt", cyc_cnt_o, 32'd41);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
